ssr_i2c_sequencer: RTL

// - Sequences the shared I2C master for the speech front end: replays a fixed config table into the

---
 rtl/ssr_i2c_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ssr_i2c_sequencer.sv
// I2C command sequencer for the speech front end: replays the ADC config table after reset,
// then issues one DATA_REG read per sample tick while a record window is open.
module ssr_i2c_sequencer #(
    parameter logic [6:0]            DEV_ADDR    = 7'h48,
    parameter int unsigned           CFG_LEN     = 3,
    parameter logic [CFG_LEN*24-1:0] CFG_TABLE   = 72'h03_0100_02_0080_01_C383,
    parameter logic [7:0]            DATA_REG    = 8'h00,
    parameter int unsigned           SAMPLE_DIV  = 625,
    parameter int unsigned           NUM_SAMPLES = 8000,
    parameter int unsigned           MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [6:0]  cmd_addr,
    output logic [7:0]  cmd_reg,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [15:0] rsp_rdata,
    output logic        sample_valid,
    output logic [15:0] sample_data,
    output logic        cfg_done,
    output logic        rec_active,
    output logic        overrun,
    output logic        fault
);

    localparam int CIW = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;
    localparam int TW  = $clog2(SAMPLE_DIV);
    localparam int SCW = $clog2(NUM_SAMPLES + 1);
    localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]  TICK_RELOAD = TW'(SAMPLE_DIV - 1);
    localparam logic [CIW-1:0] CFG_LAST    = CIW'(CFG_LEN - 1);
    localparam logic [SCW-1:0] SMP_LAST    = SCW'(NUM_SAMPLES - 1);
    localparam logic [RW-1:0]  RETRY_LAST  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        CFG_ISSUE,
        CFG_WAIT,
        IDLE,
        REC_TICK,
        RD_ISSUE,
        RD_WAIT,
        FAULT
    } state_t;

    state_t          state_q, state_d;
    logic            armed_q;
    logic            start_prev_q;
    logic [CIW-1:0]  cfg_idx_q, cfg_idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SCW-1:0]  smp_cnt_q, smp_cnt_d;
    logic [15:0]     sample_data_q, sample_data_d;
    logic            sample_valid_q, sample_valid_d;
    logic            cfg_done_q, cfg_done_d;
    logic            rec_active_q, rec_active_d;
    logic            overrun_q, overrun_d;
    logic            fault_q, fault_d;

    logic [23:0]     cfg_rom [CFG_LEN];
    logic [23:0]     cfg_entry;
    logic            issuing, handshake, in_wait, rsp_ok, rsp_bad;
    logic            retry_max, last_cfg, last_smp, start_edge, tick;

    for (genvar g = 0; g < CFG_LEN; g++) begin : g_rom
        assign cfg_rom[g] = CFG_TABLE[g*24 +: 24];
    end

    assign cfg_entry  = cfg_rom[cfg_idx_q];
    assign issuing    = armed_q && (state_q == CFG_ISSUE || state_q == RD_ISSUE);
    assign handshake  = issuing && cmd_ready;
    assign in_wait    = (state_q == CFG_WAIT) || (state_q == RD_WAIT);
    assign rsp_ok     = in_wait && rsp_valid && !rsp_nack;
    assign rsp_bad    = in_wait && rsp_valid && rsp_nack;
    assign retry_max  = (retry_q == RETRY_LAST);
    assign last_cfg   = (cfg_idx_q == CFG_LAST);
    assign last_smp   = (smp_cnt_q == SMP_LAST);
    assign start_edge = start && !start_prev_q;
    assign tick       = rec_active_q && (tick_cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CFG_ISSUE;
        else        state_q <= state_d;
    end

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CFG_ISSUE: if (handshake) state_d = CFG_WAIT;
            CFG_WAIT: begin
                if (rsp_ok)       state_d = last_cfg ? IDLE : CFG_ISSUE;
                else if (rsp_bad) state_d = retry_max ? FAULT : CFG_ISSUE;
            end
            IDLE:      if (start_edge) state_d = REC_TICK;
            REC_TICK:  if (tick) state_d = RD_ISSUE;
            RD_ISSUE:  if (handshake) state_d = RD_WAIT;
            RD_WAIT: begin
                if (rsp_ok)       state_d = last_smp ? IDLE : REC_TICK;
                else if (rsp_bad) state_d = retry_max ? FAULT : RD_ISSUE;
            end
            FAULT:     state_d = FAULT;
            default:   state_d = FAULT;
        endcase
    end

    always_comb begin
        cfg_idx_d      = cfg_idx_q;
        retry_d        = retry_q;
        tick_cnt_d     = tick_cnt_q;
        smp_cnt_d      = smp_cnt_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = 1'b0;
        cfg_done_d     = cfg_done_q;
        rec_active_d   = rec_active_q;
        overrun_d      = overrun_q;
        fault_d        = fault_q;

        if (rec_active_q) tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - TW'(1);

        // Retry budget is shared by config writes and sample reads; any success refills it.
        if (rsp_ok) begin
            retry_d = '0;
        end else if (rsp_bad) begin
            if (!retry_max) begin
                retry_d = retry_q + RW'(1);
            end else begin
                fault_d      = 1'b1;
                rec_active_d = 1'b0;
            end
        end

        case (state_q)
            CFG_WAIT: if (rsp_ok) begin
                if (last_cfg) cfg_done_d = 1'b1;
                else          cfg_idx_d  = cfg_idx_q + CIW'(1);
            end
            IDLE: if (start_edge) begin
                rec_active_d = 1'b1;
                tick_cnt_d   = TICK_RELOAD;
                smp_cnt_d    = '0;
            end
            RD_WAIT: if (rsp_ok) begin
                sample_data_d  = rsp_rdata;
                sample_valid_d = 1'b1;
                smp_cnt_d      = smp_cnt_q + SCW'(1);
                if (last_smp) rec_active_d = 1'b0;
            end
            default: ;
        endcase

        // A tick that finds a read still in flight is dropped, not queued.
        if (tick && (state_q == RD_ISSUE || state_q == RD_WAIT)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q        <= 1'b0;
            start_prev_q   <= 1'b0;
            cfg_idx_q      <= '0;
            retry_q        <= '0;
            tick_cnt_q     <= '0;
            smp_cnt_q      <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            cfg_done_q     <= 1'b0;
            rec_active_q   <= 1'b0;
            overrun_q      <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            armed_q        <= 1'b1;
            start_prev_q   <= start;
            cfg_idx_q      <= cfg_idx_d;
            retry_q        <= retry_d;
            tick_cnt_q     <= tick_cnt_d;
            smp_cnt_q      <= smp_cnt_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            cfg_done_q     <= cfg_done_d;
            rec_active_q   <= rec_active_d;
            overrun_q      <= overrun_d;
            fault_q        <= fault_d;
        end
    end

    // Command fields are forced to zero when not valid so the bus is all-zero in reset.
    always_comb begin
        cmd_valid    = issuing;
        cmd_rw       = issuing && (state_q == RD_ISSUE);
        cmd_addr     = issuing ? DEV_ADDR : 7'h00;
        cmd_reg      = 8'h00;
        cmd_wdata    = 16'h0000;
        if (issuing && state_q == RD_ISSUE) begin
            cmd_reg = DATA_REG;
        end else if (issuing) begin
            cmd_reg   = cfg_entry[23:16];
            cmd_wdata = cfg_entry[15:0];
        end
        sample_valid = sample_valid_q;
        sample_data  = sample_data_q;
        cfg_done     = cfg_done_q;
        rec_active   = rec_active_q;
        overrun      = overrun_q;
        fault        = fault_q;
    end

endmodule
